// File: rtl/exe_pkg.sv
// exe_pkg: shared encodings for the execute stage
//   ALUOp codes, R-type funct codes, multiplier FSM states and
//   bit positions of the fields packed into EXE_In.
package exe_pkg;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_MUL   = 2'b11;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;
  localparam int EXE_REGDST = 3;
  localparam int EXE_ALUSRC = 2;
  localparam int EXE_OP_HI  = 1;
  localparam int EXE_OP_LO  = 0;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;
endpackage

// File: rtl/exe_stage_if.sv
// exe_stage_if: ID/EXE inputs and EXE/MEM outputs of the execute stage
//   master: pipeline/testbench side, drives ID/EXE fields, sees results and stall
//   slave : exe_stage side
interface exe_stage_if #(parameter int WIDTH = 32, parameter int REG_W = 5);
  logic             validIn;
  logic             flush;
  logic [WIDTH-1:0] signExIn;
  logic [WIDTH-1:0] readData1In;
  logic [WIDTH-1:0] readData2In;
  logic [WIDTH-1:0] PC_In;
  logic [3:0]       EXE_In;
  logic [2:0]       M_In;
  logic [1:0]       WB_In;
  logic [REG_W-1:0] dest1In;
  logic [REG_W-1:0] dest2In;
  logic             stall;
  logic [WIDTH-1:0] aluResOut;
  logic [WIDTH-1:0] writeDataOut;
  logic [WIDTH-1:0] branchTargetOut;
  logic             zeroOut;
  logic [REG_W-1:0] destOut;
  logic [2:0]       M_Out;
  logic [1:0]       WB_Out;
  logic             validOut;
  modport master (
    output validIn, flush, signExIn, readData1In, readData2In, PC_In,
           EXE_In, M_In, WB_In, dest1In, dest2In,
    input  stall, aluResOut, writeDataOut, branchTargetOut, zeroOut,
           destOut, M_Out, WB_Out, validOut
  );
  modport slave (
    input  validIn, flush, signExIn, readData1In, readData2In, PC_In,
           EXE_In, M_In, WB_In, dest1In, dest2In,
    output stall, aluResOut, writeDataOut, branchTargetOut, zeroOut,
           destOut, M_Out, WB_Out, validOut
  );
endinterface

// File: rtl/exe_stage_iter_mul.sv
// iter_mul: iterative shift-add multiplier (low WIDTH bits of a*b)
//   in : clk, rst (async, active-low), start, flush, a, b
//   out: busy (BUSY state), done (DONE state, product valid), product
//   Build option MUL_RADIX4_EN: two multiplier bits per BUSY cycle.
module iter_mul
  import exe_pkg::*;
#(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);
`ifdef MUL_RADIX4_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH / STEP - 1);
  mul_state_t state;
  logic [WIDTH-1:0] ma, mb, acc, addend;
  logic [CW-1:0] cnt;
`ifdef MUL_RADIX4_EN
  // 0, A, 2A or 3A selected by the two low multiplier bits
  assign addend = (mb[0] ? ma : '0) + (mb[1] ? (ma << 1) : '0);
`else
  assign addend = mb[0] ? ma : '0;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      ma    <= '0;
      mb    <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (flush) state <= IDLE;
    else case (state)
      IDLE: if (start) begin
        ma    <= a;
        mb    <= b;
        acc   <= '0;
        cnt   <= '0;
        state <= BUSY;
      end
      BUSY: begin
        acc <= acc + addend;
        ma  <= ma << STEP;
        mb  <= mb >> STEP;
        cnt <= cnt + 1'b1;
        if (cnt == LAST) state <= DONE;
      end
      default: state <= IDLE;
    endcase
  assign busy    = state == BUSY;
  assign done    = state == DONE;
  assign product = acc;
endmodule

// File: rtl/exe_stage.sv
// exe_stage: MIPS execute stage with ALU, dest mux and EXE/MEM register
//   clk, rst (async, active-low), bus (exe_stage_if.slave: ID/EXE fields in,
//   EXE/MEM fields and combinational stall out).
//   MUL runs on iter_mul; build option MUL_RADIX4_EN selects radix-4 stepping.
module exe_stage
  import exe_pkg::*;
#(parameter int WIDTH = 32, parameter int REG_W = 5) (
  input logic        clk,
  input logic        rst,
  exe_stage_if.slave bus
);
  logic [1:0]       op;
  logic [5:0]       funct;
  logic [WIDTH-1:0] a, b, rtype, alu_res, product;
  logic [REG_W-1:0] dest;
  logic             mul_start, busy, done, load;
  assign op    = bus.EXE_In[EXE_OP_HI:EXE_OP_LO];
  assign funct = bus.signExIn[5:0];
  assign a     = bus.readData1In;
  assign b     = bus.EXE_In[EXE_ALUSRC] ? bus.signExIn : bus.readData2In;
  assign dest  = bus.EXE_In[EXE_REGDST] ? bus.dest2In : bus.dest1In;
  always_comb begin
    rtype   = funct == F_ADD ? a + b :
              funct == F_SUB ? a - b :
              funct == F_AND ? a & b :
              funct == F_OR  ? a | b :
              funct == F_SLT ? {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)} : '0;
    alu_res = op == ALU_ADD ? a + b :
              op == ALU_SUB ? a - b :
              op == ALU_RTYPE ? rtype : product;
  end
  assign mul_start = bus.validIn & (op == ALU_MUL);
  // in DONE the held MUL is not a new request: stall drops so it retires
  assign bus.stall = !bus.flush & (busy | (mul_start & !done));
  assign load      = bus.validIn & !bus.flush & !bus.stall;
  iter_mul #(.WIDTH(WIDTH)) u_mul (
    .clk, .rst, .start(mul_start), .flush(bus.flush),
    .a, .b, .busy, .done, .product
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bus.aluResOut       <= '0;
      bus.writeDataOut    <= '0;
      bus.branchTargetOut <= '0;
      bus.zeroOut         <= 1'b0;
      bus.destOut         <= '0;
      bus.M_Out           <= '0;
      bus.WB_Out          <= '0;
      bus.validOut        <= 1'b0;
    end else begin
      bus.aluResOut       <= load ? alu_res : '0;
      bus.writeDataOut    <= load ? bus.readData2In : '0;
      bus.branchTargetOut <= load ? bus.PC_In + (bus.signExIn << 2) : '0;
      bus.zeroOut         <= load & (alu_res == '0);
      bus.destOut         <= load ? dest : '0;
      bus.M_Out           <= load ? bus.M_In : '0;
      bus.WB_Out          <= load ? bus.WB_In : '0;
      bus.validOut        <= load;
    end
endmodule

// File: tb/tb_exe_stage.sv
// tb_exe_stage: directed scoreboard bench for exe_stage
module tb_exe_stage;
`ifdef MUL_RADIX4_EN
  localparam int MUL_STALL = 17;
`else
  localparam int MUL_STALL = 33;
`endif
  typedef struct packed {
    logic [31:0] res;
    logic [31:0] wd;
    logic [31:0] bt;
    logic        zero;
    logic [4:0]  dest;
    logic [2:0]  m;
    logic [1:0]  wb;
    logic        valid;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;
  exp_t q[$];
  exe_stage_if #(.WIDTH(32), .REG_W(5)) bus ();
  exe_stage #(.WIDTH(32), .REG_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic v, input logic f, input logic [31:0] a,
      input logic [31:0] rd2, input logic [31:0] imm, input logic [31:0] pc,
      input logic [3:0] exe, input logic [2:0] m, input logic [1:0] wb,
      input logic [4:0] d1, input logic [4:0] d2);
    exp_t e;
    logic [31:0] bb, r;
    e = '0;
    if (!v || f) return e;
    bb = exe[2] ? imm : rd2;
    case (exe[1:0])
      2'b00: r = a + bb;
      2'b01: r = a - bb;
      2'b10: case (imm[5:0])
        6'h20: r = a + bb;
        6'h22: r = a - bb;
        6'h24: r = a & bb;
        6'h25: r = a | bb;
        6'h2A: r = ($signed(a) < $signed(bb)) ? 32'd1 : 32'd0;
        default: r = 32'd0;
      endcase
      default: r = a * bb;
    endcase
    e.res = r; e.wd = rd2; e.bt = pc + (imm << 2); e.zero = (r == 0);
    e.dest = exe[3] ? d2 : d1; e.m = m; e.wb = wb; e.valid = 1'b1;
    return e;
  endfunction

  task automatic drive(input logic v, input logic f, input logic [31:0] a,
      input logic [31:0] rd2, input logic [31:0] imm, input logic [31:0] pc,
      input logic [3:0] exe, input logic [2:0] m, input logic [1:0] wb,
      input logic [4:0] d1, input logic [4:0] d2);
    bus.validIn = v; bus.flush = f; bus.readData1In = a; bus.readData2In = rd2;
    bus.signExIn = imm; bus.PC_In = pc; bus.EXE_In = exe; bus.M_In = m;
    bus.WB_In = wb; bus.dest1In = d1; bus.dest2In = d2;
    #1;
  endtask

  task automatic tick_check();
    exp_t e;
    @(posedge clk);
    #1;
    check("sb_nonempty", 32'(q.size() != 0), 32'd1);
    e = (q.size() != 0) ? q.pop_front() : '0;
    check("validOut", 32'(bus.validOut), 32'(e.valid));
    check("aluResOut", bus.aluResOut, e.res);
    check("writeDataOut", bus.writeDataOut, e.wd);
    check("branchTargetOut", bus.branchTargetOut, e.bt);
    check("zeroOut", 32'(bus.zeroOut), 32'(e.zero));
    check("destOut", 32'(bus.destOut), 32'(e.dest));
    check("M_Out", 32'(bus.M_Out), 32'(e.m));
    check("WB_Out", 32'(bus.WB_Out), 32'(e.wb));
  endtask

  task automatic issue(input logic v, input logic f, input logic [31:0] a,
      input logic [31:0] rd2, input logic [31:0] imm, input logic [31:0] pc,
      input logic [3:0] exe, input logic [2:0] m, input logic [1:0] wb,
      input logic [4:0] d1, input logic [4:0] d2);
    drive(v, f, a, rd2, imm, pc, exe, m, wb, d1, d2);
    q.push_back(model(v, f, a, rd2, imm, pc, exe, m, wb, d1, d2));
    tick_check();
  endtask

  task automatic run_mul(input logic [31:0] a, input logic [31:0] rd2, input logic [4:0] d2);
    int n;
    drive(1, 0, a, rd2, 32'h0, 32'h200, 4'b1011, 3'b010, 2'b01, 5'd1, d2);
    check("mul_stall_first", 32'(bus.stall), 32'd1);
    n = 0;
    while (bus.stall && n < 200) begin
      q.push_back('0);
      tick_check();
      n++;
    end
    check("mul_stall_cycles", 32'(n), 32'(MUL_STALL));
    q.push_back(model(1, 0, a, rd2, 32'h0, 32'h200, 4'b1011, 3'b010, 2'b01, 5'd1, d2));
    tick_check();
  endtask

  task automatic reset_zero_checks();
    check("rst_validOut", 32'(bus.validOut), 32'd0);
    check("rst_aluResOut", bus.aluResOut, 32'd0);
    check("rst_writeDataOut", bus.writeDataOut, 32'd0);
    check("rst_branchTargetOut", bus.branchTargetOut, 32'd0);
    check("rst_zeroOut", 32'(bus.zeroOut), 32'd0);
    check("rst_destOut", 32'(bus.destOut), 32'd0);
    check("rst_M_Out", 32'(bus.M_Out), 32'd0);
    check("rst_WB_Out", 32'(bus.WB_Out), 32'd0);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 4'b0, 3'b0, 2'b0, 5'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_zero_checks();
    check("rst_stall", 32'(bus.stall), 32'd0);
    rst = 1'b1;
    // R-type add wraps into the sign bit
    issue(1, 0, 32'h7FFFFFFF, 32'h1, 32'h20, 32'h40, 4'b1010, 3'b101, 2'b11, 5'd3, 5'd7);
    // sub with immediate, zero flag, branch target
    issue(1, 0, 32'h5, 32'hDEAD, 32'h5, 32'h100, 4'b0101, 3'b001, 2'b10, 5'd9, 5'd12);
    // slt signed: -1 < 1
    issue(1, 0, 32'hFFFFFFFF, 32'h1, 32'h2A, 32'h0, 4'b1010, 3'b000, 2'b11, 5'd1, 5'd2);
    issue(1, 0, 32'h1, 32'hFFFFFFFF, 32'h2A, 32'h0, 4'b1010, 3'b000, 2'b11, 5'd1, 5'd2);
    issue(1, 0, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h24, 32'h8, 4'b1010, 3'b000, 2'b11, 5'd4, 5'd5);
    issue(1, 0, 32'hF0F0_1234, 32'h0FF0_0000, 32'h25, 32'h8, 4'b1010, 3'b000, 2'b11, 5'd4, 5'd5);
    issue(1, 0, 32'h0000_0003, 32'h0000_0005, 32'h22, 32'h8, 4'b1010, 3'b000, 2'b11, 5'd4, 5'd5);
    issue(1, 0, 32'h1234, 32'h5678, 32'h27, 32'h8, 4'b1010, 3'b000, 2'b11, 5'd4, 5'd5);
    issue(1, 0, 32'h1000, 32'h77, 32'hFFFFFFFC, 32'h300, 4'b0100, 3'b100, 2'b01, 5'd6, 5'd8);
    // bubbles: invalid and flushed
    issue(0, 0, 32'h1, 32'h2, 32'h20, 32'h4, 4'b1010, 3'b111, 2'b11, 5'd1, 5'd2);
    issue(1, 1, 32'h1, 32'h2, 32'h20, 32'h4, 4'b1010, 3'b111, 2'b11, 5'd1, 5'd2);
    // multiply, then a second multiply starting right after DONE
    run_mul(32'h12345678, 32'h9, 5'd17);
    run_mul(32'h3, 32'hFFFFFFFF, 5'd18);
    issue(1, 0, 32'h2, 32'h3, 32'h20, 32'h0, 4'b1010, 3'b000, 2'b11, 5'd1, 5'd2);
    // flush on BUSY cycle 10
    drive(1, 0, 32'h12345678, 32'h9, 32'h0, 32'h0, 4'b1011, 3'b010, 2'b01, 5'd1, 5'd2);
    repeat (10) begin
      q.push_back('0);
      tick_check();
    end
    check("busy_stall_before_flush", 32'(bus.stall), 32'd1);
    bus.flush = 1'b1;
    #1;
    check("flush_stall_drop", 32'(bus.stall), 32'd0);
    q.push_back('0);
    tick_check();
    issue(1, 0, 32'h10, 32'h20, 32'h20, 32'h0, 4'b1010, 3'b011, 2'b10, 5'd1, 5'd2);
    // flush and MUL arriving together: MUL must not start
    drive(1, 1, 32'h5, 32'h6, 32'h0, 32'h0, 4'b1011, 3'b010, 2'b01, 5'd1, 5'd2);
    check("flush_mul_stall", 32'(bus.stall), 32'd0);
    q.push_back('0);
    tick_check();
    issue(1, 0, 32'h8, 32'h3, 32'h22, 32'h40, 4'b1010, 3'b011, 2'b10, 5'd1, 5'd2);
    // asynchronous reset with nonzero registered outputs
    drive(1, 0, 32'hAAAA, 32'h5555, 32'h20, 32'h80, 4'b1010, 3'b111, 2'b11, 5'd21, 5'd22);
    q.push_back(model(1, 0, 32'hAAAA, 32'h5555, 32'h20, 32'h80, 4'b1010, 3'b111, 2'b11, 5'd21, 5'd22));
    tick_check();
    drive(0, 0, 0, 0, 0, 0, 4'b0, 3'b0, 2'b0, 5'd0, 5'd0);
    #2 rst = 1'b0;
    #1;
    reset_zero_checks();
    @(posedge clk);
    #1 rst = 1'b1;
    // reset mid-BUSY, then a full-length multiply
    drive(1, 0, 32'h7, 32'h7, 32'h0, 32'h0, 4'b1011, 3'b010, 2'b01, 5'd1, 5'd2);
    repeat (6) begin
      q.push_back('0);
      tick_check();
    end
    drive(0, 0, 0, 0, 0, 0, 4'b0, 3'b0, 2'b0, 5'd0, 5'd0);
    #2 rst = 1'b0;
    #1;
    check("midbusy_rst_stall", 32'(bus.stall), 32'd0);
    reset_zero_checks();
    @(posedge clk);
    #1 rst = 1'b1;
    run_mul(32'hFFFF0001, 32'h0001FFFF, 5'd30);
    check("sb_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
